// File: rtl/wbio_master.sv
// Wishbone pipelined bus master: issues single writes or 1..16-beat reads,
// returns one response per ack, aborts on bus error or no-progress timeout.
module wbio_master #(
  parameter int AW      = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_stb,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [31:0]   i_cmd_data,
  input  logic [3:0]    i_cmd_len,
  input  logic          i_cmd_inc,
  output logic          o_cmd_busy,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data,
  output logic          o_rsp_stb,
  output logic [31:0]   o_rsp_data,
  output logic          o_rsp_err,
  output logic          o_rsp_last,
  output logic [AW-1:0] o_buserr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_nx;
  logic          inc;
  logic [4:0]    nbeats, issued, acked;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] ack_addr;
  logic          accept, issue, abort, ack_ok, last_issue, last_ack;

  assign o_cmd_busy = (state != IDLE);

  // An ack may arrive in the same cycle its strobe issues, so the issue of this
  // cycle already counts towards the acks that can be accepted.
  always_comb begin
    accept     = i_cmd_stb && (state == IDLE);
    issue      = o_wb_stb && !i_wb_stall;
    abort      = o_wb_cyc && (i_wb_err || (to_cnt == TW'(TIMEOUT)));
    ack_ok     = o_wb_cyc && i_wb_ack && !i_wb_err && (acked < (issued + {4'd0, issue}));
    last_issue = issue && ((issued + 5'd1) == nbeats);
    last_ack   = ack_ok && ((acked + 5'd1) == nbeats);
    state_nx   = state;
    case (state)
      IDLE: if (accept) state_nx = REQ;
      REQ: begin
        if (abort || last_ack) state_nx = IDLE;
        else if (last_issue)   state_nx = WAIT;
      end
      WAIT: if (abort || last_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_addr  <= '0;
      o_wb_data  <= '0;
      o_rsp_stb  <= 1'b0;
      o_rsp_data <= '0;
      o_rsp_err  <= 1'b0;
      o_rsp_last <= 1'b0;
      o_buserr   <= '0;
      inc        <= 1'b0;
      nbeats     <= '0;
      issued     <= '0;
      acked      <= '0;
      to_cnt     <= '0;
      ack_addr   <= '0;
    end else begin
      o_rsp_stb  <= 1'b0;
      o_rsp_err  <= 1'b0;
      o_rsp_last <= 1'b0;
      if (accept) begin
        o_wb_cyc  <= 1'b1;
        o_wb_stb  <= 1'b1;
        o_wb_we   <= i_cmd_we;
        o_wb_addr <= i_cmd_addr;
        o_wb_data <= i_cmd_data;
        inc       <= i_cmd_inc;
        nbeats    <= i_cmd_we ? 5'd1 : ({1'b0, i_cmd_len} + 5'd1);
        issued    <= '0;
        acked     <= '0;
        to_cnt    <= '0;
        ack_addr  <= i_cmd_addr;
      end else if (abort) begin
        // ack_addr tracks the oldest beat still waiting for its ack
        o_wb_cyc   <= 1'b0;
        o_wb_stb   <= 1'b0;
        o_rsp_stb  <= 1'b1;
        o_rsp_err  <= 1'b1;
        o_rsp_last <= 1'b1;
        o_rsp_data <= '0;
        o_buserr   <= ack_addr;
      end else begin
        if (issue) begin
          issued <= issued + 5'd1;
          if (inc)        o_wb_addr <= o_wb_addr + AW'(1);
          if (last_issue) o_wb_stb  <= 1'b0;
        end
        if (ack_ok) begin
          acked      <= acked + 5'd1;
          o_rsp_stb  <= 1'b1;
          o_rsp_data <= o_wb_we ? 32'd0 : i_wb_data;
          if (inc) ack_addr <= ack_addr + AW'(1);
          if (last_ack) begin
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_rsp_last <= 1'b1;
          end
        end
        if (issue || ack_ok) to_cnt <= '0;
        else if (o_wb_cyc)   to_cnt <= to_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wbio_master.sv
// Bench for wbio_master: a cycle-driven Wishbone slave model pushes expected
// responses into a scoreboard; each scenario task compares what the master returned.
module tb_wbio_master;

  localparam int AW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_stb, cmd_we, cmd_inc;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_data;
  logic [3:0]    cmd_len;
  logic          cmd_busy;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_wdata;
  logic          wb_ack, wb_stall, wb_err;
  logic [31:0]   wb_rdata;
  logic          rsp_stb, rsp_err, rsp_last;
  logic [31:0]   rsp_data;
  logic [AW-1:0] buserr;

  always #5 clk = ~clk;

  wbio_master #(.AW(AW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_stb(cmd_stb), .i_cmd_we(cmd_we), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
    .i_cmd_len(cmd_len), .i_cmd_inc(cmd_inc), .o_cmd_busy(cmd_busy),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
    .i_wb_data(wb_rdata), .o_rsp_stb(rsp_stb), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_rsp_last(rsp_last), .o_buserr(buserr)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        last;
  } rsp_t;

  rsp_t          exp_q[$];
  rsp_t          obs_q[$];
  logic [AW-1:0] addr_q[$];
  int            checks = 0;
  int            errors = 0;
  int            stb_cycles, end_k, last_rsp_k;
  bit            hung;
  logic          cap_cyc0, cap_we;
  logic [31:0]   cap_data;
  logic [AW-1:0] cap_addr;

  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    return 32'hC0DE_0000 + 32'(a) * 32'h0000_0111;
  endfunction

  // Drives one command and plays the slave until o_wb_cyc drops. Called at a negedge.
  task automatic run_bus(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                         input logic [3:0] len, input logic inc, input int lat,
                         input int stall_beat, input int stall_cyc, input int err_beat,
                         input bit stall_all, input int rst_at);
    int            due_q[$];
    logic [AW-1:0] pa_q[$];
    int            nbeats, beats, acks, stall_left;
    bit            stop;
    nbeats = we ? 1 : int'(len) + 1;
    beats = 0; acks = 0; stall_left = stall_cyc; stop = 0;
    stb_cycles = 0; hung = 1; end_k = -1; last_rsp_k = -1;
    exp_q.delete(); obs_q.delete(); addr_q.delete();
    cmd_stb = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_len = len; cmd_inc = inc;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cmd_stb = 1'b0;
      rst = 1'b0;
      if (k == 0) begin
        cap_cyc0 = wb_cyc; cap_we = wb_we; cap_data = wb_wdata; cap_addr = wb_addr;
      end
      if (rsp_stb) begin
        obs_q.push_back('{rsp_data, rsp_err, rsp_last});
        last_rsp_k = k;
      end
      if (!wb_cyc) begin
        hung = 0;
        end_k = k;
        break;
      end
      if (wb_stb) stb_cycles++;
      wb_stall = 1'b0;
      if (wb_stb) begin
        if (stall_all) wb_stall = 1'b1;
        else if (beats == stall_beat && stall_left > 0) begin
          wb_stall = 1'b1;
          stall_left--;
        end
      end
      if (wb_stb && !wb_stall) begin
        addr_q.push_back(wb_addr);
        due_q.push_back(k + lat);
        pa_q.push_back(wb_addr);
        beats++;
      end
      wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = '0;
      if (k == rst_at) rst = 1'b1;
      else if (!stop && due_q.size() > 0 && due_q[0] == k) begin
        if (acks == err_beat) begin
          wb_ack = 1'b1; wb_err = 1'b1; stop = 1;
          exp_q.push_back('{32'd0, 1'b1, 1'b1});
        end else begin
          wb_ack = 1'b1;
          wb_rdata = mem(pa_q[0]);
          exp_q.push_back('{(we ? 32'd0 : mem(pa_q[0])), 1'b0, (acks == nbeats - 1)});
        end
        void'(due_q.pop_front());
        void'(pa_q.pop_front());
        acks++;
      end
    end
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = '0; rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_stb = 1'b1; cmd_we = 1'b1; cmd_addr = 5'h1F; cmd_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({wb_cyc, wb_stb, wb_we, rsp_stb, rsp_err, rsp_last, cmd_busy} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {wb_cyc, wb_stb, wb_we, rsp_stb, rsp_err, rsp_last, cmd_busy});
    end
    checks++;
    if ({wb_addr, wb_wdata, rsp_data, buserr} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {wb_addr, wb_wdata, rsp_data, buserr});
    end
    rst = 1'b0; cmd_stb = 1'b0; wb_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rsp_stb !== 1'b0 || cmd_busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_stray_ack got rsp_stb=%b busy=%b want 0 0", rsp_stb, cmd_busy);
      end
    end
    wb_ack = 1'b0;
  endtask

  task automatic test_write;
    @(negedge clk);
    checks++;
    if (cmd_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_before got %b want 0", cmd_busy); end
    run_bus(1'b1, 5'h05, 32'h0000_00F3, 4'd0, 1'b0, 1, -1, 0, -1, 0, -1);
    checks++;
    if (hung !== 1'b0) begin errors++; $display("FAIL wr_done got hung=%b want 0", hung); end
    checks++;
    if ({cap_cyc0, cap_we, cap_addr, cap_data} !== {1'b1, 1'b1, 5'h05, 32'h0000_00F3}) begin
      errors++;
      $display("FAIL wr_first_cycle got cyc=%b we=%b addr=%h data=%h want 1 1 05 000000f3", cap_cyc0, cap_we, cap_addr, cap_data);
    end
    checks++;
    if (stb_cycles !== 1) begin errors++; $display("FAIL wr_stb_cycles got %0d want 1", stb_cycles); end
    checks++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
      errors++;
      $display("FAIL wr_rsp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wr_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (last_rsp_k !== end_k) begin
      errors++;
      $display("FAIL wr_cyc_low_with_rsp got rsp_k=%0d end_k=%0d want equal", last_rsp_k, end_k);
    end
  endtask

  task automatic test_read_stall;
    logic [AW-1:0] want;
    @(negedge clk);
    run_bus(1'b0, 5'h08, 32'h0, 4'd3, 1'b1, 2, 1, 2, -1, 0, -1);
    checks++;
    if (hung !== 1'b0) begin errors++; $display("FAIL rd_stall_done got hung=%b want 0", hung); end
    checks++;
    if (addr_q.size() !== 4) begin errors++; $display("FAIL rd_stall_beats got %0d want 4", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 4; i++) begin
      want = 5'h08 + AW'(i);
      checks++;
      if (addr_q[i] !== want) begin
        errors++;
        $display("FAIL rd_stall_addr[%0d] got %h want %h", i, addr_q[i], want);
      end
    end
    checks++;
    if (obs_q.size() !== 4 || exp_q.size() !== 4) begin
      errors++;
      $display("FAIL rd_stall_rsp_count got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rd_stall_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_read_wrap;
    logic [AW-1:0] want;
    @(negedge clk);
    run_bus(1'b0, 5'h1E, 32'h0, 4'd15, 1'b1, 0, -1, 0, -1, 0, -1);
    checks++;
    if (hung !== 1'b0) begin errors++; $display("FAIL wrap_done got hung=%b want 0", hung); end
    checks++;
    if (addr_q.size() !== 16) begin errors++; $display("FAIL wrap_beats got %0d want 16", addr_q.size()); end
    for (int i = 0; i < addr_q.size() && i < 16; i++) begin
      want = 5'h1E + AW'(i);
      checks++;
      if (addr_q[i] !== want) begin
        errors++;
        $display("FAIL wrap_addr[%0d] got %h want %h", i, addr_q[i], want);
      end
    end
    checks++;
    if (obs_q.size() !== 16 || exp_q.size() !== 16) begin
      errors++;
      $display("FAIL wrap_rsp_count got %0d want 16", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bus_error;
    @(negedge clk);
    run_bus(1'b0, 5'h10, 32'h0, 4'd2, 1'b1, 1, -1, 0, 1, 0, -1);
    checks++;
    if (hung !== 1'b0) begin errors++; $display("FAIL err_done got hung=%b want 0", hung); end
    checks++;
    if (obs_q.size() !== 2 || exp_q.size() !== 2) begin
      errors++;
      $display("FAIL err_rsp_count got %0d want 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL err_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (buserr !== 5'h11) begin errors++; $display("FAIL err_buserr got %h want 11", buserr); end
    checks++;
    if ({wb_cyc, wb_stb, cmd_busy} !== 3'b000) begin
      errors++;
      $display("FAIL err_idle got cyc/stb/busy=%b want 000", {wb_cyc, wb_stb, cmd_busy});
    end
  endtask

  task automatic test_timeout;
    rsp_t want;
    @(negedge clk);
    run_bus(1'b0, 5'h0C, 32'h0, 4'd1, 1'b1, 1, -1, 0, -1, 1, -1);
    want = '{32'd0, 1'b1, 1'b1};
    checks++;
    if (hung !== 1'b0) begin errors++; $display("FAIL to_done got hung=%b want 0", hung); end
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL to_rsp_count got %0d want 1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] !== want) begin errors++; $display("FAIL to_rsp got %h want %h", obs_q[0], want); end
    end
    checks++;
    if (stb_cycles !== TO + 1) begin errors++; $display("FAIL to_cycles got %0d want %0d", stb_cycles, TO + 1); end
    checks++;
    if (buserr !== 5'h0C) begin errors++; $display("FAIL to_buserr got %h want 0c", buserr); end
    checks++;
    if (cmd_busy !== 1'b0) begin errors++; $display("FAIL to_busy got %b want 0", cmd_busy); end
    run_bus(1'b1, 5'h03, 32'hDEAD_BEEF, 4'd0, 1'b1, 1, -1, 0, -1, 0, -1);
    checks++;
    if ({cap_cyc0, cap_we, cap_addr, cap_data} !== {1'b1, 1'b1, 5'h03, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL to_b2b_accept got cyc=%b we=%b addr=%h data=%h want 1 1 03 deadbeef", cap_cyc0, cap_we, cap_addr, cap_data);
    end
    checks++;
    if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL to_b2b_rsp got %0d responses want 1 matching", obs_q.size());
    end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    run_bus(1'b0, 5'h04, 32'h0, 4'd3, 1'b1, 6, -1, 0, -1, 0, 5);
    checks++;
    if (hung !== 1'b0 || end_k !== 6) begin
      errors++;
      $display("FAIL rst_mid_drop got hung=%b end_k=%0d want 0 6", hung, end_k);
    end
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL rst_mid_rsp got %0d want 0", obs_q.size()); end
    checks++;
    if ({wb_stb, cmd_busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_idle got stb/busy=%b want 00", {wb_stb, cmd_busy});
    end
    @(negedge clk);
    checks++;
    if ({rsp_stb, wb_cyc} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_after got rsp_stb/cyc=%b want 00", {rsp_stb, wb_cyc});
    end
  endtask

  initial begin
    rst = 1'b1; cmd_stb = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_len = '0;
    cmd_inc = 1'b0; wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0; wb_rdata = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read_stall();
    test_read_wrap();
    test_bus_error();
    test_timeout();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
